stream_take_n: RTL and testbench
================================

// Module: stream_take_n
// PURPOSE
//  Parametrised successor to the fixed-arity stream "ap" primitives (ap01, ap02).
//  On each activation it pops the first N elements of an input stream into N
//  registered scalar outputs, then optionally forwards the rest of the stream.
//  Sits between a stream producer and scalar consumers in generated dataflow
//  graphs, using the standard in_valid/in_ready/out_valid/out_ready sync wrapper.
// PARAMETERS
//  W    8  element width in bits (all streams and scalars)
//  N    2  elements popped per activation, N >= 1
//  FWD  1  1: forward the remaining stream to sOut after capture;
//          0: sOut_valid stays 0 and sIn_ready stays 0 outside CAPTURE
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  in_valid    in   1    activation request
//  in_ready    out  1    block can accept an activation
//  out_valid   out  1    dOut holds N captured elements
//  out_ready   in   1    consumer accepts dOut
//  sIn         in   W    input stream data
//  sIn_valid   in   1    sIn carries an element
//  sIn_ready   out  1    block takes sIn this cycle
//  sOut        out  W    remainder stream data
//  sOut_valid  out  1    sOut carries an element
//  sOut_ready  in   1    downstream takes sOut
//  dOut        out  N*W  captured elements; element k at dOut[k*W +: W], k=0 is first popped
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, dOut=0, out_valid=0. Outputs are
//   then in_ready=1, sIn_ready=0, sOut_valid=0.
//  States: IDLE, CAPTURE, HOLD, PASS. cnt has width clog2(N+1) and counts captured elements.
//  IDLE: in_ready=1. in_valid -> CAPTURE at the next edge with cnt=0.
//  CAPTURE: in_ready=0, sIn_ready=1, sOut_valid=0.
//   - Each sIn_valid cycle writes sIn to dOut[cnt] and increments cnt.
//   - On the cycle that writes element N-1: next state HOLD, and out_valid=1 from the next cycle.
//   - With sIn_valid=0 the state stalls. There is no timeout.
//  HOLD: out_valid=1, sIn_ready=0, in_ready=0, dOut is stable.
//   - out_ready -> out_valid=0 next cycle.
//   - Next state is PASS if FWD=1, else IDLE.
//  PASS (FWD=1 only): in_ready=1.
//   - Combinational forwarding: sOut=sIn, sOut_valid=sIn_valid, sIn_ready=sOut_ready.
//   - dOut keeps its last value.
//   - in_valid in PASS ends forwarding: the same cycle still forwards, and the
//     next edge goes to CAPTURE with cnt=0.
//  Latency: activation to first possible capture is 1 cycle. With sIn_valid held 1,
//   out_valid rises N+1 cycles after the activation edge.
//  Element order: strictly FIFO. No element is duplicated or dropped, except
//   elements offered while sIn_ready=0, which are not taken.
//  out_ready is ignored when out_valid=0. sOut_ready is ignored outside PASS.
//  N=1: the first capture goes directly to HOLD.
//  Reset asserted mid-CAPTURE or mid-HOLD: partially captured data is discarded,
//   dOut=0, and no out_valid pulse is produced.
// TESTING
//  Bench uses W=8, N=2, FWD=1 unless noted. sIn counts 1,2,3,... with sIn_valid=1.
//  1 Basic: rst, then in_valid pulse at cycle 0 -> dOut[0]=1, dOut[1]=2, out_valid=1 at
//    cycle 3. With out_ready=1, sOut then carries 3,4,5,... one per cycle.
//  2 Backpressure: out_ready=0 for 4 cycles in HOLD -> out_valid stays 1, dOut stays
//    {2,1}, sIn_ready=0, no element is lost. After release, the first sOut element is 3.
//  3 Gaps: sIn_valid toggles 1,0,1 during CAPTURE -> out_valid is delayed by 1 cycle
//    and dOut={2,1}. In PASS, sOut_ready=0 drives sIn_ready=0 and no sOut element is lost.
//  4 Reactivation: in_valid in PASS while sIn=5 -> 5 forwarded on sOut;
//    next dOut={7,6}, out_valid asserted again.
//  5 Reset mid-capture: rst after element 1 captured -> dOut=0, out_valid=0, in_ready=1
//    within the same cycle. A new activation captures fresh values correctly.
//  6 Params: N=1, FWD=0 -> dOut=1, out_valid at cycle 2, sOut_valid never 1.
//    W=16, N=4 -> dOut[k]=k+1.

Source files
------------

// File: rtl/stream_take_n_if.sv
// Handshake and data bundle for stream_take_n: activation request, captured
// scalars, and the input/remainder element streams.
interface stream_take_n_if #(
    parameter int W = 8,
    parameter int N = 2
);
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sIn;
    logic           sIn_valid;
    logic           sIn_ready;
    logic [W-1:0]   sOut;
    logic           sOut_valid;
    logic           sOut_ready;
    logic [N*W-1:0] dOut;

    // Block side
    modport slave (
        input  in_valid, out_ready, sIn, sIn_valid, sOut_ready,
        output in_ready, out_valid, sIn_ready, sOut, sOut_valid, dOut
    );

    // Environment side (producer, scalar consumer, remainder consumer)
    modport master (
        output in_valid, out_ready, sIn, sIn_valid, sOut_ready,
        input  in_ready, out_valid, sIn_ready, sOut, sOut_valid, dOut
    );
endinterface

// File: rtl/stream_take_n.sv
// Pops the first N elements of a stream into N registered scalars per activation,
// then optionally forwards the rest of the stream until the next activation.
module stream_take_n #(
    parameter int W   = 8,
    parameter int N   = 2,
    parameter bit FWD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    stream_take_n_if.slave  io
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        PASS    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            capture_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture_en    = 1'b0;
        io.in_ready   = 1'b0;
        io.out_valid  = 1'b0;
        io.sIn_ready  = 1'b0;
        io.sOut_valid = 1'b0;
        case (state_q)
            IDLE: begin
                io.in_ready = 1'b1;
                if (io.in_valid) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                io.sIn_ready = 1'b1;
                if (io.sIn_valid) begin
                    capture_en = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                io.out_valid = 1'b1;
                if (io.out_ready) begin
                    state_d = FWD ? PASS : IDLE;
                end
            end
            PASS: begin
                if (FWD) begin
                    // Activation here still forwards this cycle's element
                    io.in_ready   = 1'b1;
                    io.sOut_valid = io.sIn_valid;
                    io.sIn_ready  = io.sOut_ready;
                    if (io.in_valid) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.sOut = io.sIn;

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        logic [W-1:0] slot_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= '0;
            end else if (capture_en && (cnt_q == CW'(gi))) begin
                slot_q <= io.sIn;
            end
        end

        assign io.dOut[gi*W +: W] = slot_q;
    end
endmodule

// File: tb/tb_stream_take_n.sv
// Self-checking bench for stream_take_n: directed scenarios plus randomized
// activations checked against a source-sequence model of the captured elements.
module tb_stream_take_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_take_n_if #(.W(8),  .N(2)) bus0 ();
    stream_take_n_if #(.W(8),  .N(1)) bus1 ();
    stream_take_n_if #(.W(16), .N(4)) bus2 ();

    stream_take_n #(.W(8),  .N(2), .FWD(1'b1)) dut0 (.clk(clk), .rst(rst), .io(bus0.slave));
    stream_take_n #(.W(8),  .N(1), .FWD(1'b0)) dut1 (.clk(clk), .rst(rst), .io(bus1.slave));
    stream_take_n #(.W(16), .N(4), .FWD(1'b1)) dut2 (.clk(clk), .rst(rst), .io(bus2.slave));

    int n_cmp = 0;
    int n_bad = 0;
    // Next element each producer offers; advances only when an element is taken
    logic [7:0]  src0 = 8'd0;
    logic [7:0]  src1 = 8'd0;
    logic [15:0] src2 = 16'd0;

    task automatic drive_defaults();
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.sIn_valid = 1'b0; bus0.sOut_ready = 1'b0; bus0.sIn = src0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.sIn_valid = 1'b0; bus1.sOut_ready = 1'b0; bus1.sIn = src1;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.sIn_valid = 1'b0; bus2.sOut_ready = 1'b0; bus2.sIn = src2;
    endtask

    task automatic tick();
        logic t0, t1, t2;
        t0 = bus0.sIn_valid && bus0.sIn_ready;
        t1 = bus1.sIn_valid && bus1.sIn_ready;
        t2 = bus2.sIn_valid && bus2.sIn_ready;
        @(posedge clk);
        #1;
        if (t0) src0 = src0 + 8'd1;
        if (t1) src1 = src1 + 8'd1;
        if (t2) src2 = src2 + 16'd1;
        bus0.sIn = src0;
        bus1.sIn = src1;
        bus2.sIn = src2;
    endtask

    task automatic do_reset();
        drive_defaults();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_defaults();
        rst = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.sIn_valid = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++;
        if ({bus0.in_ready, bus0.sIn_ready, bus0.sOut_valid, bus0.out_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected %b",
                     {bus0.in_ready, bus0.sIn_ready, bus0.sOut_valid, bus0.out_valid}, 4'b1000);
        end
        n_cmp++;
        if (bus0.dOut !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_dout: got %h expected %h", bus0.dOut, 16'h0000);
        end
        n_cmp++;
        if ({bus1.out_valid, bus2.out_valid, bus2.dOut} !== {2'b00, 64'h0}) begin
            n_bad++;
            $display("FAIL reset_params: got %b%b %h expected 00 0", bus1.out_valid, bus2.out_valid, bus2.dOut);
        end
        rst = 1'b0;
        drive_defaults();
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        src0 = 8'd1; bus0.sIn = src0;
        bus0.sIn_valid = 1'b1; bus0.out_ready = 1'b1; bus0.sOut_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus0.in_valid = (c == 0);
            #1;
            n_cmp++;
            if (bus0.out_valid !== (c == 3)) begin
                n_bad++;
                $display("FAIL basic_out_valid c=%0d: got %b expected %b", c, bus0.out_valid, (c == 3));
            end
            if (c == 3) begin
                n_cmp++;
                if (bus0.dOut !== 16'h0201) begin
                    n_bad++;
                    $display("FAIL basic_dout: got %h expected %h", bus0.dOut, 16'h0201);
                end
            end
            if (c >= 4) begin
                n_cmp++;
                if ({bus0.sOut_valid, bus0.sOut} !== {1'b1, 8'(c - 1)}) begin
                    n_bad++;
                    $display("FAIL basic_sout c=%0d: got %b/%0d expected 1/%0d", c, bus0.sOut_valid, bus0.sOut, c - 1);
                end
            end
            tick();
        end
        $display("test_basic done");
    endtask

    task automatic test_backpressure();
        do_reset();
        src0 = 8'd1; bus0.sIn = src0;
        bus0.sIn_valid = 1'b1; bus0.sOut_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            bus0.in_valid  = (c == 0);
            bus0.out_ready = (c >= 7);
            #1;
            n_cmp++;
            if (bus0.out_valid !== (c >= 3 && c <= 7)) begin
                n_bad++;
                $display("FAIL bp_out_valid c=%0d: got %b expected %b", c, bus0.out_valid, (c >= 3 && c <= 7));
            end
            if (c >= 3 && c <= 7) begin
                n_cmp++;
                if ({bus0.dOut, bus0.sIn_ready} !== {16'h0201, 1'b0}) begin
                    n_bad++;
                    $display("FAIL bp_hold c=%0d: got %h/%b expected 0201/0", c, bus0.dOut, bus0.sIn_ready);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if ({bus0.sOut_valid, bus0.sOut} !== {1'b1, 8'd3}) begin
                    n_bad++;
                    $display("FAIL bp_first_sout: got %b/%0d expected 1/3", bus0.sOut_valid, bus0.sOut);
                end
            end
            tick();
        end
        $display("test_backpressure done");
    endtask

    task automatic test_gaps();
        logic [5:0] rpat;
        logic [7:0] exp_s;
        rpat  = 6'b100101;
        exp_s = 8'd3;
        do_reset();
        src0 = 8'd1; bus0.sIn = src0;
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus0.in_valid  = (c == 0);
            bus0.sIn_valid = (c != 2);
            #1;
            n_cmp++;
            if (bus0.out_valid !== (c == 4)) begin
                n_bad++;
                $display("FAIL gaps_out_valid c=%0d: got %b expected %b", c, bus0.out_valid, (c == 4));
            end
            if (c == 4) begin
                n_cmp++;
                if (bus0.dOut !== 16'h0201) begin
                    n_bad++;
                    $display("FAIL gaps_dout: got %h expected %h", bus0.dOut, 16'h0201);
                end
            end
            tick();
        end
        bus0.sIn_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus0.sOut_ready = rpat[c];
            #1;
            n_cmp++;
            if ({bus0.sIn_ready, bus0.sOut_valid, bus0.sOut} !== {rpat[c], 1'b1, exp_s}) begin
                n_bad++;
                $display("FAIL gaps_pass c=%0d: got %b/%b/%0d expected %b/1/%0d",
                         c, bus0.sIn_ready, bus0.sOut_valid, bus0.sOut, rpat[c], exp_s);
            end
            if (rpat[c]) exp_s = exp_s + 8'd1;
            tick();
        end
        $display("test_gaps done");
    endtask

    task automatic test_reactivation();
        do_reset();
        src0 = 8'd1; bus0.sIn = src0;
        bus0.sIn_valid = 1'b1; bus0.out_ready = 1'b1; bus0.sOut_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus0.in_valid = (c == 0 || c == 6);
            #1;
            if (c == 6) begin
                n_cmp++;
                if ({bus0.in_ready, bus0.sOut_valid, bus0.sOut} !== {2'b11, 8'd5}) begin
                    n_bad++;
                    $display("FAIL react_forward: got %b%b/%0d expected 11/5", bus0.in_ready, bus0.sOut_valid, bus0.sOut);
                end
            end
            n_cmp++;
            if (bus0.out_valid !== (c == 3 || c == 9)) begin
                n_bad++;
                $display("FAIL react_out_valid c=%0d: got %b expected %b", c, bus0.out_valid, (c == 3 || c == 9));
            end
            if (c == 9) begin
                n_cmp++;
                if (bus0.dOut !== 16'h0706) begin
                    n_bad++;
                    $display("FAIL react_dout: got %h expected %h", bus0.dOut, 16'h0706);
                end
            end
            tick();
        end
        $display("test_reactivation done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        src0 = 8'd1; bus0.sIn = src0;
        bus0.sIn_valid = 1'b1; bus0.out_ready = 1'b1;
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (bus0.dOut !== 16'h0001) begin
            n_bad++;
            $display("FAIL rmid_partial: got %h expected %h", bus0.dOut, 16'h0001);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus0.dOut, bus0.out_valid, bus0.in_ready} !== {16'h0000, 2'b01}) begin
            n_bad++;
            $display("FAIL rmid_async: got %h/%b/%b expected 0000/0/1", bus0.dOut, bus0.out_valid, bus0.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus0.in_valid = (c == 0);
            #1;
            n_cmp++;
            if (bus0.out_valid !== (c == 3)) begin
                n_bad++;
                $display("FAIL rmid_out_valid c=%0d: got %b expected %b", c, bus0.out_valid, (c == 3));
            end
            if (c == 3) begin
                n_cmp++;
                if (bus0.dOut !== 16'h0302) begin
                    n_bad++;
                    $display("FAIL rmid_dout: got %h expected %h", bus0.dOut, 16'h0302);
                end
            end
            tick();
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_params();
        do_reset();
        src1 = 8'd1;  bus1.sIn = src1;
        src2 = 16'd1; bus2.sIn = src2;
        bus1.sIn_valid = 1'b1; bus1.out_ready = 1'b1; bus1.sOut_ready = 1'b1;
        bus2.sIn_valid = 1'b1; bus2.out_ready = 1'b1; bus2.sOut_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus1.in_valid = (c == 0);
            bus2.in_valid = (c == 0);
            #1;
            n_cmp++;
            if ({bus1.out_valid, bus1.sOut_valid} !== {(c == 2), 1'b0}) begin
                n_bad++;
                $display("FAIL n1_valids c=%0d: got %b%b expected %b0", c, bus1.out_valid, bus1.sOut_valid, (c == 2));
            end
            if (c == 2) begin
                n_cmp++;
                if (bus1.dOut !== 8'd1) begin
                    n_bad++;
                    $display("FAIL n1_dout: got %h expected %h", bus1.dOut, 8'd1);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({bus1.in_ready, bus1.sIn_ready} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL n1_idle: got %b expected 10", {bus1.in_ready, bus1.sIn_ready});
                end
            end
            n_cmp++;
            if (bus2.out_valid !== (c == 5)) begin
                n_bad++;
                $display("FAIL n4_out_valid c=%0d: got %b expected %b", c, bus2.out_valid, (c == 5));
            end
            if (c == 5) begin
                n_cmp++;
                if (bus2.dOut !== 64'h0004_0003_0002_0001) begin
                    n_bad++;
                    $display("FAIL n4_dout: got %h expected %h", bus2.dOut, 64'h0004_0003_0002_0001);
                end
            end
            tick();
        end
        $display("test_params done");
    endtask

    task automatic test_random();
        logic [7:0]  base;
        logic [15:0] exp_d;
        logic        sv, sr, done;
        int          got, nh, np;
        do_reset();
        src0 = 8'($urandom); bus0.sIn = src0;
        for (int t = 0; t < 30; t++) begin
            // activation cycle, from IDLE on the first pass and from PASS afterwards
            sv = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
            bus0.sIn_valid = sv; bus0.sOut_ready = sr;
            #1;
            n_cmp++;
            if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
                n_bad++;
                $display("FAIL rnd_activate t=%0d: got %b expected 10", t, {bus0.in_ready, bus0.out_valid});
            end
            tick();
            bus0.in_valid = 1'b0;
            base = src0;
            exp_d = {base + 8'd1, base};
            got = 0;
            done = 1'b0;
            for (int k = 0; k < 64; k++) begin
                bus0.sIn_valid = ($urandom_range(0, 9) < 7);
                #1;
                if (got == 2) begin
                    done = 1'b1;
                    break;
                end
                n_cmp++;
                if ({bus0.out_valid, bus0.sIn_ready, bus0.in_ready, bus0.sOut_valid} !== 4'b0100) begin
                    n_bad++;
                    $display("FAIL rnd_capture t=%0d k=%0d: got %b expected 0100", t, k,
                             {bus0.out_valid, bus0.sIn_ready, bus0.in_ready, bus0.sOut_valid});
                end
                if (bus0.sIn_valid) got++;
                tick();
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rnd_timeout t=%0d: got %0d captures expected 2", t, got);
                break;
            end
            nh = $urandom_range(0, 3);
            for (int h = 0; h <= nh; h++) begin
                bus0.out_ready = (h == nh);
                bus0.sIn_valid = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if ({bus0.out_valid, bus0.sIn_ready, bus0.in_ready, bus0.dOut} !== {3'b100, exp_d}) begin
                    n_bad++;
                    $display("FAIL rnd_hold t=%0d h=%0d: got %b/%h expected 100/%h", t, h,
                             {bus0.out_valid, bus0.sIn_ready, bus0.in_ready}, bus0.dOut, exp_d);
                end
                tick();
            end
            bus0.out_ready = 1'b0;
            $display("txn %0d: base=%0d dOut=%h hold=%0d", t, base, exp_d, nh);
            np = $urandom_range(0, 4);
            for (int p = 0; p < np; p++) begin
                sv = 1'($urandom_range(0, 1));
                sr = 1'($urandom_range(0, 1));
                bus0.sIn_valid = sv; bus0.sOut_ready = sr;
                #1;
                n_cmp++;
                if ({bus0.sOut_valid, bus0.sIn_ready, bus0.in_ready, bus0.out_valid, bus0.sOut}
                        !== {sv, sr, 2'b10, src0}) begin
                    n_bad++;
                    $display("FAIL rnd_pass t=%0d p=%0d: got %b/%0d expected %b%b10/%0d", t, p,
                             {bus0.sOut_valid, bus0.sIn_ready, bus0.in_ready, bus0.out_valid}, bus0.sOut, sv, sr, src0);
                end
                tick();
            end
        end
        $display("test_random done");
    endtask

    initial begin
        drive_defaults();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reactivation();
        test_reset_mid();
        test_params();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end
endmodule
